fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Pipelined-CPU instruction fetch stage plus IF/ID pipeline register.
//  - Holds the PC and issues requests to a variable-latency instruction memory.
//  - Delivers instr_D/op_D/funct_D to the decode-stage control unit, with a valid bit.
//  - Supports decode stalls and branch redirects resolved in MEM.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  PC_STEP   4              byte increment applied to the PC per accepted instruction
// PORTS
//  clk         in   1   clock; all state updates on its rising edge
//  reset       in   1   asynchronous, active-high reset
//  stall_D     in   1   decode stalled: hold IF/ID, do not advance PC
//  pcSrc_M     in   1   branch taken in MEM: redirect PC, flush IF/ID
//  pcBranch_M  in   32  redirect target, valid when pcSrc_M=1
//  imem_req    out  1   instruction memory request
//  imem_addr   out  32  request address; stable while imem_req=1
//  imem_rdata  in   32  instruction word, valid when imem_ready=1
//  imem_ready  in   1   memory response; completes the pending request
//  instr_D     out  32  IF/ID instruction; 0 (nop) when not valid
//  pcPlus4_D   out  32  IF/ID fetched PC + PC_STEP
//  op_D        out  6   instr_D[31:26]
//  funct_D     out  6   instr_D[5:0]
//  valid_D     out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (async) values:
//  - pc_F=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC.
//  - instr_D=0, pcPlus4_D=0, valid_D=0. The hold buffer is cleared.
//  States:
//  - IDLE: imem_req=0. Next cycle -> FETCH.
//  - FETCH: imem_req=1, imem_addr=pc_F.
//  - HOLD: imem_req=0. The hold buffer contains a fetched word.
//  - KILL: imem_req=1 with the old address; the pending response is to be discarded.
//  FETCH:
//  - ready & !pcSrc_M & !stall_D: IF/ID <= {rdata, pc_F+PC_STEP, valid=1}; pc_F += PC_STEP.
//  - ready & !pcSrc_M & stall_D: buffer <= rdata; IF/ID holds -> HOLD.
//  - ready & pcSrc_M: drop rdata; pc_F <= pcBranch_M; IF/ID flushed; stay in FETCH.
//  - !ready & pcSrc_M: target reg <= pcBranch_M; IF/ID flushed -> KILL.
//  - !ready & !pcSrc_M: IF/ID holds if stall_D; otherwise IF/ID <= bubble (valid 0, instr 0).
//  HOLD:
//  - !stall_D: IF/ID <= buffer; pc_F += PC_STEP -> FETCH.
//  - pcSrc_M: buffer dropped; pc_F <= pcBranch_M; IF/ID flushed -> FETCH.
//  KILL:
//  - On ready: drop rdata; pc_F <= target -> FETCH.
//  - A further pcSrc_M overwrites target (last one wins).
//  - IF/ID bubbles while in KILL.
//  Rules:
//  - A request, once raised, is never withdrawn or readdressed before imem_ready.
//  - Priority: reset > pcSrc_M (flush) > stall_D > capture.
//  - A flush forces instr_D=0, valid_D=0 even while stall_D=1.
//  - Latency: response accepted at edge N appears on instr_D after edge N.
//  - Zero-wait memory (ready tied 1) sustains one instruction per cycle.
//  - Arithmetic: PC add is 32-bit, wraps 32'hFFFF_FFFC -> 0, no overflow flag.
//  - op_D and funct_D are pure slices of instr_D.
// TESTING
//  1. Reset, ready=1, no stalls -> imem_addr 0,4,8,..; pcPlus4_D 4,8,12; valid_D=1 from cycle 2.
//  2. Response ready after 3 cycles -> imem_addr held at 0 for 3 cycles; valid_D=0 until accept.
//  3. stall_D=1 for 2 cycles while word 32'h0104_2020 returns -> HOLD; that word is in instr_D after release, PC=4.
//  4. pcSrc_M=1, pcBranch_M=32'h40 during wait -> KILL; stale word dropped; next imem_addr=32'h40; valid_D=0.
//  5. pcSrc_M with stall_D=1 -> instr_D=0, valid_D=0 next cycle; no word lost from the target.
//  6. Reset asserted mid-KILL -> outputs return to reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, imem handshake and IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_D,
    input  logic        pcSrc_M,
    input  logic [31:0] pcBranch_M,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr_D,
    output logic [31:0] pcPlus4_D,
    output logic [5:0]  op_D,
    output logic [5:0]  funct_D,
    output logic        valid_D
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, KILL} state_t;

    state_t      state, stateNext;
    logic [31:0] pc_F, pcNext;
    logic [31:0] holdBuf, holdNext;
    logic [31:0] target, targetNext;
    logic [31:0] instrNext, pcPlus4Next;
    logic        validNext;
    logic [31:0] pcInc;

    assign pcInc = pc_F + 32'(PC_STEP);

    // pc_F only moves once a request completes, so it is also the in-flight address
    assign imem_addr = pc_F;
    assign imem_req  = (state == FETCH) || (state == KILL);
    assign op_D      = instr_D[31:26];
    assign funct_D   = instr_D[5:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc_F      <= RESET_PC;
            holdBuf   <= 32'h0;
            target    <= 32'h0;
            instr_D   <= 32'h0;
            pcPlus4_D <= 32'h0;
            valid_D   <= 1'b0;
        end else begin
            state     <= stateNext;
            pc_F      <= pcNext;
            holdBuf   <= holdNext;
            target    <= targetNext;
            instr_D   <= instrNext;
            pcPlus4_D <= pcPlus4Next;
            valid_D   <= validNext;
        end
    end

    always_comb begin
        stateNext   = state;
        pcNext      = pc_F;
        holdNext    = holdBuf;
        targetNext  = target;
        instrNext   = instr_D;
        pcPlus4Next = pcPlus4_D;
        validNext   = valid_D;
        case (state)
            IDLE: begin
                stateNext = FETCH;
                if (pcSrc_M) begin
                    pcNext    = pcBranch_M;
                    instrNext = 32'h0;
                    validNext = 1'b0;
                end
            end
            FETCH: begin
                if (imem_ready) begin
                    if (pcSrc_M) begin
                        pcNext    = pcBranch_M;
                        instrNext = 32'h0;
                        validNext = 1'b0;
                    end else if (stall_D) begin
                        holdNext  = imem_rdata;
                        stateNext = HOLD;
                    end else begin
                        instrNext   = imem_rdata;
                        pcPlus4Next = pcInc;
                        validNext   = 1'b1;
                        pcNext      = pcInc;
                    end
                end else if (pcSrc_M) begin
                    // request cannot be withdrawn: park the target until it completes
                    targetNext = pcBranch_M;
                    instrNext  = 32'h0;
                    validNext  = 1'b0;
                    stateNext  = KILL;
                end else if (!stall_D) begin
                    instrNext = 32'h0;
                    validNext = 1'b0;
                end
            end
            HOLD: begin
                if (pcSrc_M) begin
                    pcNext    = pcBranch_M;
                    instrNext = 32'h0;
                    validNext = 1'b0;
                    stateNext = FETCH;
                end else if (!stall_D) begin
                    instrNext   = holdBuf;
                    pcPlus4Next = pcInc;
                    validNext   = 1'b1;
                    pcNext      = pcInc;
                    stateNext   = FETCH;
                end
            end
            KILL: begin
                instrNext = 32'h0;
                validNext = 1'b0;
                if (pcSrc_M) targetNext = pcBranch_M;
                if (imem_ready) begin
                    pcNext    = pcSrc_M ? pcBranch_M : target;
                    stateNext = FETCH;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_D = 1'b0;
    logic        pcSrc_M = 1'b0;
    logic [31:0] pcBranch_M = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ready = 1'b0;
    logic [31:0] instr_D;
    logic [31:0] pcPlus4_D;
    logic [5:0]  op_D;
    logic [5:0]  funct_D;
    logic        valid_D;

    int checks = 0;
    int failures = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall_D(stall_D), .pcSrc_M(pcSrc_M),
        .pcBranch_M(pcBranch_M), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .instr_D(instr_D),
        .pcPlus4_D(pcPlus4_D), .op_D(op_D), .funct_D(funct_D), .valid_D(valid_D)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, pcSrc, ready;
        logic [31:0] br, rdata;
        logic        eReq;
        logic [31:0] eAddr, eInstr, eP4;
        logic        eValid;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(logic rst, logic stall, logic pcSrc, logic [31:0] br,
                                logic ready, logic [31:0] rdata, logic eReq,
                                logic [31:0] eAddr, logic [31:0] eInstr,
                                logic [31:0] eP4, logic eValid);
        vec_t v;
        v.rst = rst; v.stall = stall; v.pcSrc = pcSrc; v.br = br;
        v.ready = ready; v.rdata = rdata; v.eReq = eReq; v.eAddr = eAddr;
        v.eInstr = eInstr; v.eP4 = eP4; v.eValid = eValid;
        return v;
    endfunction

    task automatic check(string name, int row, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic checkOut(int row, logic eReq, logic [31:0] eAddr, logic [31:0] eInstr,
                            logic [31:0] eP4, logic eValid);
        check("imem_req", row, {31'h0, imem_req}, {31'h0, eReq});
        check("imem_addr", row, imem_addr, eAddr);
        check("instr_D", row, instr_D, eInstr);
        check("pcPlus4_D", row, pcPlus4_D, eP4);
        check("valid_D", row, {31'h0, valid_D}, {31'h0, eValid});
        check("op_D", row, {26'h0, op_D}, {26'h0, eInstr[31:26]});
        check("funct_D", row, {26'h0, funct_D}, {26'h0, eInstr[5:0]});
    endtask

    task automatic applyVec(int row, vec_t v);
        @(negedge clk);
        reset = v.rst; stall_D = v.stall; pcSrc_M = v.pcSrc; pcBranch_M = v.br;
        imem_ready = v.ready; imem_rdata = v.rdata;
        @(posedge clk);
        #1;
        checkOut(row, v.eReq, v.eAddr, v.eInstr, v.eP4, v.eValid);
    endtask

    initial begin
        //            rst st  br  target         rdy rdata          req addr           instr          pcPlus4        v
        vecs[0]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0);
        vecs[1]  = mk(0, 0, 0, 32'h0,        1, 32'hA0A0_A0A0, 1, 32'h0,        32'h0,        32'h0,        0);
        vecs[2]  = mk(0, 0, 0, 32'h0,        1, 32'h1111_0001, 1, 32'h4,        32'h1111_0001, 32'h4,        1);
        vecs[3]  = mk(0, 0, 0, 32'h0,        1, 32'h2222_0002, 1, 32'h8,        32'h2222_0002, 32'h8,        1);
        vecs[4]  = mk(0, 0, 0, 32'h0,        1, 32'h3333_0003, 1, 32'hC,        32'h3333_0003, 32'hC,        1);
        vecs[5]  = mk(0, 0, 0, 32'h0,        0, 32'hBAD0_0000, 1, 32'hC,        32'h0,        32'hC,        0);
        vecs[6]  = mk(0, 0, 0, 32'h0,        0, 32'hBAD0_0001, 1, 32'hC,        32'h0,        32'hC,        0);
        vecs[7]  = mk(0, 0, 0, 32'h0,        1, 32'h4444_0004, 1, 32'h10,       32'h4444_0004, 32'h10,       1);
        vecs[8]  = mk(0, 1, 0, 32'h0,        1, 32'h0104_2020, 0, 32'h10,       32'h4444_0004, 32'h10,       1);
        vecs[9]  = mk(0, 1, 0, 32'h0,        0, 32'hBAD0_0002, 0, 32'h10,       32'h4444_0004, 32'h10,       1);
        vecs[10] = mk(0, 0, 0, 32'h0,        0, 32'hBAD0_0003, 1, 32'h14,       32'h0104_2020, 32'h14,       1);
        vecs[11] = mk(0, 0, 1, 32'h40,       0, 32'hBAD0_0004, 1, 32'h14,       32'h0,        32'h14,       0);
        vecs[12] = mk(0, 0, 0, 32'h0,        0, 32'hBAD0_0005, 1, 32'h14,       32'h0,        32'h14,       0);
        vecs[13] = mk(0, 0, 0, 32'h0,        1, 32'hDEAD_BEEF, 1, 32'h40,       32'h0,        32'h14,       0);
        vecs[14] = mk(0, 0, 0, 32'h0,        1, 32'h5555_0005, 1, 32'h44,       32'h5555_0005, 32'h44,       1);
        vecs[15] = mk(0, 1, 0, 32'h0,        0, 32'hBAD0_0006, 1, 32'h44,       32'h5555_0005, 32'h44,       1);
        vecs[16] = mk(0, 1, 1, 32'h80,       1, 32'hDEAD_BEEF, 1, 32'h80,       32'h0,        32'h44,       0);
        vecs[17] = mk(0, 0, 0, 32'h0,        1, 32'h6666_0006, 1, 32'h84,       32'h6666_0006, 32'h84,       1);
        vecs[18] = mk(0, 1, 0, 32'h0,        1, 32'h7777_0007, 0, 32'h84,       32'h6666_0006, 32'h84,       1);
        vecs[19] = mk(0, 1, 1, 32'h64,       0, 32'hBAD0_0007, 1, 32'h64,       32'h0,        32'h84,       0);
        vecs[20] = mk(0, 0, 0, 32'h0,        1, 32'h8888_0008, 1, 32'h68,       32'h8888_0008, 32'h68,       1);
        vecs[21] = mk(0, 0, 1, 32'h200,      0, 32'hBAD0_0008, 1, 32'h68,       32'h0,        32'h68,       0);
        vecs[22] = mk(0, 0, 1, 32'h300,      0, 32'hBAD0_0009, 1, 32'h68,       32'h0,        32'h68,       0);
        vecs[23] = mk(0, 0, 0, 32'h0,        1, 32'hDEAD_BEEF, 1, 32'h300,      32'h0,        32'h68,       0);
        vecs[24] = mk(0, 0, 0, 32'h0,        1, 32'h9999_0009, 1, 32'h304,      32'h9999_0009, 32'h304,      1);
        vecs[25] = mk(0, 0, 1, 32'hFFFF_FFFC, 1, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFC, 32'h0,        32'h304,      0);
        vecs[26] = mk(0, 0, 0, 32'h0,        1, 32'hABCD_EF3F, 1, 32'h0,        32'hABCD_EF3F, 32'h0,        1);

        #2 reset = 1'b1;
        #1 checkOut(-1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < 27; i++) applyVec(i, vecs[i]);

        // asynchronous reset while a killed request is still outstanding
        applyVec(100, mk(0, 0, 0, 32'h0, 1, 32'h1234_5678, 1, 32'h4, 32'h1234_5678, 32'h4, 1));
        applyVec(101, mk(0, 0, 1, 32'h500, 0, 32'hBAD0_000A, 1, 32'h4, 32'h0, 32'h4, 0));
        @(negedge clk);
        pcSrc_M = 1'b0;
        #2 reset = 1'b1;
        #1 checkOut(102, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        applyVec(103, mk(0, 0, 0, 32'h0, 1, 32'hBAD0_000B, 1, 32'h0, 32'h0, 32'h0, 0));
        applyVec(104, mk(0, 0, 0, 32'h0, 1, 32'hCAFE_0010, 1, 32'h4, 32'hCAFE_0010, 32'h4, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
